// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter plus APB SETUP/ACCESS sequencer for NUM_REQ local requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES cycles without PREADY.
module apb_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SW = APB_DATA_WIDTH/8,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rst_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [NUM_REQ-1:0]          req_write_in,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_in,
  input  logic [NUM_REQ*SW-1:0]       req_strb_in,
  input  logic [NUM_REQ*3-1:0]        req_prot_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  output logic [NUM_REQ-1:0]          resp_valid_out,
  output logic [APB_DATA_WIDTH-1:0]   resp_rdata_out,
  output logic                        resp_error_out,
  output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
  output logic                        apb_psel_out,
  output logic                        apb_penable_out,
  output logic                        apb_write_out,
  output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
  output logic [SW-1:0]               apb_strb_out,
  output logic [2:0]                  apb_prot_out,
  input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
  input  logic                        apb_ready_in,
  input  logic                        apb_slverr_in
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e state_q, state_d;
  logic [GW-1:0]      last_grant, win_idx;
  logic               win_found, done, launch, to_hit;
  logic [NUM_REQ-1:0] cand, grant_oh;

  logic [NUM_REQ-1:0][APB_ADDR_WIDTH-1:0] addr_a;
  logic [NUM_REQ-1:0][APB_DATA_WIDTH-1:0] wdata_a;
  logic [NUM_REQ-1:0][SW-1:0]             strb_a;
  logic [NUM_REQ-1:0][2:0]                prot_a;

  assign addr_a  = req_addr_in;
  assign wdata_a = req_wdata_in;
  assign strb_a  = req_strb_in;
  assign prot_a  = req_prot_in;

  always_comb begin
    grant_oh             = '0;
    grant_oh[last_grant] = 1'b1;
  end

  // On the completion cycle the requester just served is not eligible again.
  assign cand = (state_q == ACCESS) ? (req_valid_in & ~grant_oh) : req_valid_in;

  always_comb begin : rr_pick
    logic [GW-1:0] pidx;
    win_found = 1'b0;
    win_idx   = '0;
    pidx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pidx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && cand[pidx]) begin
        win_found = 1'b1;
        win_idx   = pidx;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in || state_q == SETUP) to_cnt <= '0;
    else if (state_q == ACCESS && !apb_ready_in) to_cnt <= to_cnt + 1'b1;
  end

  // PREADY on the limit cycle takes precedence, hence the !apb_ready_in term.
  assign to_hit = (state_q == ACCESS) && !apb_ready_in && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  assign done   = (state_q == ACCESS) && (apb_ready_in || to_hit);
  assign launch = win_found && ((state_q == IDLE) || done);

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = win_found ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      last_grant      <= GW'(NUM_REQ - 1);
      req_ready_out   <= '0;
      resp_valid_out  <= '0;
      resp_rdata_out  <= '0;
      resp_error_out  <= 1'b0;
      apb_addr_out    <= '0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
      apb_write_out   <= 1'b0;
      apb_wdata_out   <= '0;
      apb_strb_out    <= '0;
      apb_prot_out    <= '0;
    end else begin
      req_ready_out  <= '0;
      resp_valid_out <= '0;
      if (state_q == SETUP) apb_penable_out <= 1'b1;
      if (done) begin
        resp_valid_out  <= grant_oh;
        resp_error_out  <= apb_ready_in ? apb_slverr_in : 1'b1;
        resp_rdata_out  <= (apb_ready_in && !apb_write_out) ? apb_rdata_in : '0;
        apb_psel_out    <= 1'b0;
        apb_penable_out <= 1'b0;
      end
      // A launch on the completion cycle overrides the bus drop above: psel stays high.
      if (launch) begin
        last_grant             <= win_idx;
        req_ready_out[win_idx] <= 1'b1;
        apb_psel_out           <= 1'b1;
        apb_penable_out        <= 1'b0;
        apb_addr_out           <= addr_a[win_idx];
        apb_wdata_out          <= wdata_a[win_idx];
        apb_strb_out           <= strb_a[win_idx];
        apb_prot_out           <= prot_a[win_idx];
        apb_write_out          <= req_write_in[win_idx];
      end
    end
  end

endmodule
